ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Successor to the keyboard-demo top level. Drains scan-code bytes from ps2_keyboard via its
//  ready/nextdata_n handshake and decodes set-2 make/break/E0-extended sequences. Tracks the
//  held key, counts new presses in a parametrised BCD counter, and drives 7-seg patterns for
//  the scan code, its ASCII value and the press count. It sits between ps2_keyboard and the
//  board segment outputs.
// PARAMETERS
//  CNT_DIGITS     2  number of BCD digits in the press counter (1..4)
//  IGNORE_REPEAT  1  1: typematic repeats of the held key do not increment the counter
//  SEG_ACTIVE_LOW 1  1: segment outputs inverted (board segments light on 0)
// PORTS
//  clk            in   1            system clock
//  resetn         in   1            asynchronous, active-low reset
//  kb_data        in   8            byte at head of ps2_keyboard FIFO
//  kb_ready       in   1            FIFO non-empty
//  kb_overflow    in   1            FIFO overflow indication
//  kb_nextdata_n  out  1            low for one cycle = pop one byte
//  clr            in   1            sync clear of counter and sticky overflow
//  key_code       out  8            last make code (low byte)
//  key_ext        out  1            last make code was E0-prefixed
//  key_held       out  1            a key is currently held
//  key_ascii      out  8            ASCII of key_code, 8'h00 if unmapped or extended
//  make_pulse     out  1            1-cycle pulse: new key pressed
//  repeat_pulse   out  1            1-cycle pulse: typematic repeat of held key
//  break_pulse    out  1            1-cycle pulse: held key released
//  press_bcd      out  4*CNT_DIGITS BCD press count, digit 0 in LSBs
//  ovf_sticky     out  1            latched kb_overflow
//  seg_code       out  16           2 hex digits of key_code, [7:0] = low nibble
//  seg_ascii      out  16           2 hex digits of key_ascii
//  seg_cnt        out  8*CNT_DIGITS one digit per BCD digit
// BEHAVIOUR
//  Reset: kb_nextdata_n=1; all other outputs 0; state IDLE. Segment buses show blank
//   (8'hFF if SEG_ACTIVE_LOW); seg_cnt shows 0s. Reset mid-sequence discards the partial prefix.
//  Handshake: when kb_ready=1 and kb_nextdata_n=1, drive kb_nextdata_n=0 for exactly one cycle.
//   kb_data is captured at that edge. kb_nextdata_n then returns to 1 for >=1 cycle, so peak
//   throughput is 1 byte per 2 cycles and no double pop occurs.
//  FSM (next state evaluated on the captured byte b):
//   IDLE : E0->E0; F0->F0; AA/FA/EE/00/FF ignored; else make(b, ext=0)
//   E0   : F0->E0F0; E0 stays E0; else make(b, ext=1) -> IDLE
//   F0   : any b -> break(b, ext=0) -> IDLE
//   E0F0 : any b -> break(b, ext=1) -> IDLE
//  make: if key_held and {ext,b}=={key_ext,key_code}, it is a repeat: repeat_pulse; the counter
//   advances only if IGNORE_REPEAT=0. Otherwise make_pulse; key_code/key_ext/key_ascii updated;
//   key_held=1; counter +1.
//  break: if {ext,b} matches the held key, break_pulse and key_held=0; key_code is retained.
//   A break of a non-held key is ignored.
//  Timing: pulses and key_* register on the edge after the capture edge. Segment outputs follow
//   one cycle later.
//  Counter: BCD ripple. Wraps all-9s -> all-0s with no flag. clr has priority over a
//   same-cycle increment (result 0). The key_* and pulse outputs still update on that cycle.
//  ovf_sticky: set on kb_overflow=1, cleared by clr. Set wins on a simultaneous clr.
//  Segments: seg_code and seg_ascii are blank while key_held=0. Hex digits 0-F use standard
//   a..g with dp off. Bit7=a ... bit1=g, bit0=dp, before the optional inversion.
// STRUCTURE
//  Package ps2_pkg holds:
//   - scan-code constants (E0, F0, AA, FA, EE)
//   - FSM state enum
//   - 16-entry hex->7seg table
//   - SEG_BLANK constant
//  Sub-module ps2_scan2ascii is a combinational set-2 ROM covering a-z, 0-9, space and enter
//   (Enter maps to 8'h0D); every other code returns 8'h00.
// TESTING
//  1 bytes 1C, F0 1C -> make_pulse, key_code=1C, key_ascii=61, press_bcd=01;
//    then break_pulse, key_held=0
//  2 bytes E0 75, E0 F0 75 -> key_ext=1, key_ascii=00; break on ext match only;
//    F0 75 (non-ext) ignored
//  3 bytes 15 15 15 F0 15 -> 1 make + 2 repeat_pulse, press_bcd=01 (IGNORE_REPEAT=1);
//    with IGNORE_REPEAT=0 -> 03
//  4 preload 99 presses (CNT_DIGITS=2), one more make -> press_bcd=00;
//    clr same cycle as make -> 00, key_held=1
//  5 kb_ready held high 6 cycles with 3 bytes queued -> kb_nextdata_n low on exactly
//    3 non-adjacent cycles
//  6 deassert resetn after E0 F0 (before final byte) -> all outputs at reset values;
//    next byte 1C decodes as plain make

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 key decoder slice.
//   - set-2 scan-code constants used by the decoder
//   - decoder FSM state type
//   - hex digit -> 7-segment pattern table (bit7=a .. bit1=g, bit0=dp)
//   - blank segment pattern (before any output inversion)
package ps2_pkg;

   localparam logic [7:0] SC_E0 = 8'hE0;   // extended prefix
   localparam logic [7:0] SC_F0 = 8'hF0;   // break prefix
   localparam logic [7:0] SC_AA = 8'hAA;   // BAT passed
   localparam logic [7:0] SC_FA = 8'hFA;   // ACK
   localparam logic [7:0] SC_EE = 8'hEE;   // echo

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_E0,
      ST_F0,
      ST_E0F0
   } state_t;

   localparam logic [7:0] SEG_BLANK = 8'h00;

   localparam logic [7:0] HEX7SEG [16] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
      8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
   };

   function automatic logic [7:0] hex7(input logic [3:0] n);
      return HEX7SEG[n];
   endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// ps2_scan2ascii: combinational set-2 scan code -> ASCII lookup.
//   scan   in  8  set-2 make code (non-extended)
//   ascii  out 8  lowercase letter, digit, space or CR; 8'h00 otherwise
module ps2_scan2ascii (
   input  logic [7:0] scan,
   output logic [7:0] ascii
);

   always_comb begin
      ascii = 8'h00;
      unique case (scan)
         8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
         8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
         8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
         8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
         8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
         8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
         8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
         8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
         8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
         8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
         8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
         8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
         8'h46: ascii = 8'h39;
         8'h29: ascii = 8'h20;  // space
         8'h5A: ascii = 8'h0D;  // enter
         default: ascii = 8'h00;
      endcase
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: drains scan-code bytes from ps2_keyboard and decodes set-2
// make / break / E0-extended sequences, tracking the held key, counting new
// presses in BCD and driving 7-segment patterns.
//   clk, resetn              clock, async active-low reset
//   kb_data/kb_ready         head byte and non-empty flag of the keyboard FIFO
//   kb_overflow              FIFO overflow (latched into ovf_sticky)
//   kb_nextdata_n            one-cycle low pops one byte
//   clr                      sync clear of press counter and ovf_sticky
//   key_code/key_ext/key_ascii/key_held   last make code and held status
//   make_pulse/repeat_pulse/break_pulse   one-cycle event pulses
//   press_bcd                BCD press count, digit 0 in LSBs
//   seg_code/seg_ascii/seg_cnt            7-segment patterns
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned CNT_DIGITS     = 2,
   parameter bit          IGNORE_REPEAT  = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [7:0]                kb_data,
   input  logic                      kb_ready,
   input  logic                      kb_overflow,
   output logic                      kb_nextdata_n,
   input  logic                      clr,
   output logic [7:0]                key_code,
   output logic                      key_ext,
   output logic                      key_held,
   output logic [7:0]                key_ascii,
   output logic                      make_pulse,
   output logic                      repeat_pulse,
   output logic                      break_pulse,
   output logic [4*CNT_DIGITS-1:0]   press_bcd,
   output logic                      ovf_sticky,
   output logic [15:0]               seg_code,
   output logic [15:0]               seg_ascii,
   output logic [8*CNT_DIGITS-1:0]   seg_cnt
);

   localparam logic [15:0]             POL16 = {16{SEG_ACTIVE_LOW}};
   localparam logic [8*CNT_DIGITS-1:0] POLC  = {(8*CNT_DIGITS){SEG_ACTIVE_LOW}};

   logic [7:0]              byte_q;
   logic                    byte_v;
   logic [7:0]              ascii_lut;
   state_t                  state, state_nxt;
   logic                    ev_make, ev_brk, ev_ext, match;
   logic                    is_new, is_rep, is_rel, cnt_inc;
   logic [4*CNT_DIGITS-1:0] press_nxt;

   function automatic logic [4*CNT_DIGITS-1:0] bcd_inc(input logic [4*CNT_DIGITS-1:0] v);
      logic [4*CNT_DIGITS-1:0] r;
      logic                    carry;
      r     = v;
      carry = 1'b1;
      for (int unsigned i = 0; i < CNT_DIGITS; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   ps2_scan2ascii u_scan2ascii (
      .scan  (byte_q),
      .ascii (ascii_lut)
   );

   // Pop only when nextdata_n is currently high, so every pop is followed by
   // at least one idle cycle and the FIFO head has time to advance.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         kb_nextdata_n <= 1'b1;
         byte_q        <= '0;
         byte_v        <= 1'b0;
      end else begin
         byte_v <= 1'b0;
         if (kb_ready && kb_nextdata_n) begin
            kb_nextdata_n <= 1'b0;
            byte_q        <= kb_data;
            byte_v        <= 1'b1;
         end else begin
            kb_nextdata_n <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ev_make   = 1'b0;
      ev_brk    = 1'b0;
      ev_ext    = 1'b0;
      if (byte_v) begin
         unique case (state)
            ST_IDLE: begin
               if (byte_q == SC_E0)
                  state_nxt = ST_E0;
               else if (byte_q == SC_F0)
                  state_nxt = ST_F0;
               else if (!(byte_q == SC_AA || byte_q == SC_FA || byte_q == SC_EE ||
                          byte_q == 8'h00 || byte_q == 8'hFF))
                  ev_make = 1'b1;
            end
            ST_E0: begin
               if (byte_q == SC_F0) begin
                  state_nxt = ST_E0F0;
               end else if (byte_q != SC_E0) begin
                  ev_make   = 1'b1;
                  ev_ext    = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            ST_F0: begin
               ev_brk    = 1'b1;
               state_nxt = ST_IDLE;
            end
            ST_E0F0: begin
               ev_brk    = 1'b1;
               ev_ext    = 1'b1;
               state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
      match     = key_held && ({ev_ext, byte_q} == {key_ext, key_code});
      is_new    = ev_make && !match;
      is_rep    = ev_make && match;
      is_rel    = ev_brk && match;
      cnt_inc   = is_new || (is_rep && !IGNORE_REPEAT);
      press_nxt = bcd_inc(press_bcd);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= ST_IDLE;
         key_code     <= '0;
         key_ext      <= 1'b0;
         key_held     <= 1'b0;
         key_ascii    <= '0;
         make_pulse   <= 1'b0;
         repeat_pulse <= 1'b0;
         break_pulse  <= 1'b0;
         press_bcd    <= '0;
         ovf_sticky   <= 1'b0;
      end else begin
         state        <= state_nxt;
         make_pulse   <= is_new;
         repeat_pulse <= is_rep;
         break_pulse  <= is_rel;
         if (is_new) begin
            key_code  <= byte_q;
            key_ext   <= ev_ext;
            key_ascii <= ev_ext ? 8'h00 : ascii_lut;
            key_held  <= 1'b1;
         end else if (is_rel) begin
            key_held  <= 1'b0;
         end
         if (clr)
            press_bcd <= '0;
         else if (cnt_inc)
            press_bcd <= press_nxt;
         if (kb_overflow)
            ovf_sticky <= 1'b1;
         else if (clr)
            ovf_sticky <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         seg_code  <= {2{SEG_BLANK}} ^ POL16;
         seg_ascii <= {2{SEG_BLANK}} ^ POL16;
         seg_cnt   <= {CNT_DIGITS{hex7(4'd0)}} ^ POLC;
      end else begin
         seg_code  <= (key_held ? {hex7(key_code[7:4]),  hex7(key_code[3:0])}
                                : {2{SEG_BLANK}}) ^ POL16;
         seg_ascii <= (key_held ? {hex7(key_ascii[7:4]), hex7(key_ascii[3:0])}
                                : {2{SEG_BLANK}}) ^ POL16;
         for (int unsigned i = 0; i < CNT_DIGITS; i++)
            seg_cnt[8*i +: 8] <= hex7(press_bcd[4*i +: 4]) ^ POLC[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  kb_data;
   logic        kb_ready;
   logic        kb_overflow;
   logic        clr;
   logic        nd, nd2;
   logic [7:0]  key_code, key_code2, key_ascii, key_ascii2;
   logic        key_ext, key_ext2, key_held, key_held2;
   logic        make_pulse, repeat_pulse, break_pulse;
   logic        make_pulse2, repeat_pulse2, break_pulse2;
   logic [7:0]  press_bcd, press_bcd2;
   logic        ovf_sticky, ovf_sticky2;
   logic [15:0] seg_code, seg_code2, seg_ascii, seg_ascii2, seg_cnt, seg_cnt2;

   logic [7:0]  mem [256];
   logic [7:0]  wr_ptr = 8'd0;
   logic [7:0]  rd_ptr = 8'd0;

   int n_cmp = 0;
   int n_bad = 0;
   int n_make = 0, n_rep = 0, n_brk = 0;

   always #5 clk = ~clk;

   // Keyboard FIFO model: head byte visible while non-empty, popped at the
   // clock edge that ends a low nextdata_n cycle.
   assign kb_ready = (rd_ptr != wr_ptr);
   assign kb_data  = mem[rd_ptr];
   always @(posedge clk)
      if (!nd && kb_ready) rd_ptr <= rd_ptr + 8'd1;

   always @(negedge clk) begin
      if (make_pulse)   n_make <= n_make + 1;
      if (repeat_pulse) n_rep  <= n_rep + 1;
      if (break_pulse)  n_brk  <= n_brk + 1;
   end

   ps2_key_decoder #(.CNT_DIGITS(2), .IGNORE_REPEAT(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_dut (
      .clk(clk), .resetn(resetn), .kb_data(kb_data), .kb_ready(kb_ready),
      .kb_overflow(kb_overflow), .kb_nextdata_n(nd), .clr(clr),
      .key_code(key_code), .key_ext(key_ext), .key_held(key_held), .key_ascii(key_ascii),
      .make_pulse(make_pulse), .repeat_pulse(repeat_pulse), .break_pulse(break_pulse),
      .press_bcd(press_bcd), .ovf_sticky(ovf_sticky),
      .seg_code(seg_code), .seg_ascii(seg_ascii), .seg_cnt(seg_cnt)
   );

   ps2_key_decoder #(.CNT_DIGITS(2), .IGNORE_REPEAT(1'b0), .SEG_ACTIVE_LOW(1'b1)) u_dut_rep (
      .clk(clk), .resetn(resetn), .kb_data(kb_data), .kb_ready(kb_ready),
      .kb_overflow(kb_overflow), .kb_nextdata_n(nd2), .clr(clr),
      .key_code(key_code2), .key_ext(key_ext2), .key_held(key_held2), .key_ascii(key_ascii2),
      .make_pulse(make_pulse2), .repeat_pulse(repeat_pulse2), .break_pulse(break_pulse2),
      .press_bcd(press_bcd2), .ovf_sticky(ovf_sticky2),
      .seg_code(seg_code2), .seg_ascii(seg_ascii2), .seg_cnt(seg_cnt2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr      = wr_ptr + 8'd1;
   endtask

   task automatic drain(input string tag);
      int unsigned k;
      k = 0;
      while (rd_ptr != wr_ptr && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(rd_ptr == wr_ptr), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_clr();
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
   endtask

   initial begin
      int m0, r0, b0, lows, lows2, adj;
      logic prev;
      resetn = 1'b0; clr = 1'b0; kb_overflow = 1'b0;
      repeat (3) @(negedge clk);

      // reset values
      check("rst_nd",        32'(nd),         32'h1);
      check("rst_key_code",  32'(key_code),   32'h0);
      check("rst_key_held",  32'(key_held),   32'h0);
      check("rst_press",     32'(press_bcd),  32'h0);
      check("rst_seg_code",  32'(seg_code),   32'hFFFF);
      check("rst_seg_ascii", 32'(seg_ascii),  32'hFFFF);
      check("rst_seg_cnt",   32'(seg_cnt),    32'h0303);
      @(negedge clk) resetn = 1'b1;
      repeat (2) @(negedge clk);

      // 1: make then break of 'a'
      m0 = n_make; b0 = n_brk;
      push(8'h1C);
      drain("t1_drain_a");
      check("t1_make",       32'(n_make - m0), 32'd1);
      check("t1_key_code",   32'(key_code),    32'h1C);
      check("t1_key_ascii",  32'(key_ascii),   32'h61);
      check("t1_key_held",   32'(key_held),    32'h1);
      check("t1_press",      32'(press_bcd),   32'h01);
      check("t1_seg_code",   32'(seg_code),    32'h9F63);
      check("t1_seg_ascii",  32'(seg_ascii),   32'h419F);
      check("t1_seg_cnt",    32'(seg_cnt),     32'h039F);
      push(8'hF0); push(8'h1C);
      drain("t1_drain_b");
      check("t1_break",      32'(n_brk - b0),  32'd1);
      check("t1_released",   32'(key_held),    32'h0);
      check("t1_code_kept",  32'(key_code),    32'h1C);
      check("t1_seg_blank",  32'(seg_code),    32'hFFFF);

      // 2: extended key, non-extended break ignored, extended break accepted
      b0 = n_brk;
      push(8'hE0); push(8'h75);
      drain("t2_drain_a");
      check("t2_key_code",   32'(key_code),    32'h75);
      check("t2_key_ext",    32'(key_ext),     32'h1);
      check("t2_key_ascii",  32'(key_ascii),   32'h00);
      check("t2_seg_ascii",  32'(seg_ascii),   32'h0303);
      push(8'hF0); push(8'h75);
      drain("t2_drain_b");
      check("t2_plain_brk",  32'(n_brk - b0),  32'd0);
      check("t2_still_held", 32'(key_held),    32'h1);
      push(8'hE0); push(8'hF0); push(8'h75);
      drain("t2_drain_c");
      check("t2_ext_brk",    32'(n_brk - b0),  32'd1);
      check("t2_released",   32'(key_held),    32'h0);

      // overflow sticky bit: set, clear, set-wins-over-clear
      @(negedge clk) kb_overflow = 1'b1;
      @(negedge clk) kb_overflow = 1'b0;
      check("ovf_set",       32'(ovf_sticky),  32'h1);
      pulse_clr();
      check("ovf_clr",       32'(ovf_sticky),  32'h0);
      @(negedge clk) begin kb_overflow = 1'b1; clr = 1'b1; end
      @(negedge clk) begin kb_overflow = 1'b0; clr = 1'b0; end
      check("ovf_set_wins",  32'(ovf_sticky),  32'h1);

      // 3: typematic repeats
      pulse_clr();
      m0 = n_make; r0 = n_rep; b0 = n_brk;
      push(8'h15); push(8'h15); push(8'h15); push(8'hF0); push(8'h15);
      drain("t3_drain");
      check("t3_make",       32'(n_make - m0), 32'd1);
      check("t3_repeat",     32'(n_rep - r0),  32'd2);
      check("t3_break",      32'(n_brk - b0),  32'd1);
      check("t3_press_ign",  32'(press_bcd),   32'h01);
      check("t3_press_cnt",  32'(press_bcd2),  32'h03);

      // 4: wrap at 99 and clear colliding with a make
      pulse_clr();
      for (int i = 0; i < 99; i++) push((i % 2 == 0) ? 8'h1C : 8'h32);
      drain("t4_drain_a");
      check("t4_press_99",   32'(press_bcd),   32'h99);
      check("t4_seg_cnt_99", 32'(seg_cnt),     32'h0909);
      push(8'h32);
      drain("t4_drain_b");
      check("t4_wrap",       32'(press_bcd),   32'h00);
      m0 = n_make;
      @(negedge clk) push(8'h21);
      @(posedge clk) #1 clr = 1'b1;
      @(posedge clk) #1 clr = 1'b0;
      drain("t4_drain_c");
      check("t4_clr_make",   32'(n_make - m0), 32'd1);
      check("t4_clr_press",  32'(press_bcd),   32'h00);
      check("t4_clr_held",   32'(key_held),    32'h1);
      check("t4_clr_code",   32'(key_code),    32'h21);

      // 5: handshake spacing with three queued bytes
      lows = 0; lows2 = 0; adj = 0; prev = 1'b1;
      @(negedge clk) begin push(8'h1C); push(8'h32); push(8'h21); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (!nd) lows++;
         if (!nd2) lows2++;
         if (!nd && !prev) adj++;
         prev = nd;
      end
      check("t5_pops",       32'(lows),        32'd3);
      check("t5_pops_dut2",  32'(lows2),       32'd3);
      check("t5_adjacent",   32'(adj),         32'd0);
      drain("t5_drain");
      check("t5_key_code",   32'(key_code),    32'h21);

      // 6: reset in the middle of an E0 F0 prefix
      push(8'hE0); push(8'hF0);
      drain("t6_drain_a");
      @(negedge clk) resetn = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_rst_nd",     32'(nd),          32'h1);
      check("t6_rst_code",   32'(key_code),    32'h0);
      check("t6_rst_held",   32'(key_held),    32'h0);
      check("t6_rst_ovf",    32'(ovf_sticky),  32'h0);
      check("t6_rst_seg",    32'(seg_code),    32'hFFFF);
      check("t6_rst_segcnt", 32'(seg_cnt),     32'h0303);
      @(negedge clk) resetn = 1'b1;
      repeat (2) @(negedge clk);
      m0 = n_make;
      push(8'h1C);
      drain("t6_drain_b");
      check("t6_make",       32'(n_make - m0), 32'd1);
      check("t6_key_code",   32'(key_code),    32'h1C);
      check("t6_key_ext",    32'(key_ext),     32'h0);
      check("t6_press",      32'(press_bcd),   32'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
